// File: rtl/hazard_sb_unit_pkg.sv
// Shared encodings for the decode-side hazard controller: forward-select
// values and the latencies the long-latency units report at issue.
package hazard_sb_unit_pkg;

    localparam int FWD_RF      = 0;
    localparam int MUL_LAT     = 4;
    localparam int DIV_LAT     = 0;
    localparam int LAT_UNKNOWN = 0;

    // Forward-select value for forwarding stage k (0 = youngest).
    function automatic int unsigned fwd_sel_of(input int unsigned stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/hazard_sb_unit_if.sv
// Decode/pipeline <-> hazard controller bundle. master = pipeline side,
// slave = hazard controller.
interface hazard_sb_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 3,
    parameter int MAX_LAT    = 34
);
    localparam int CNT_W  = $clog2(MAX_LAT + 1);
    localparam int FSEL_W = $clog2(FWD_STAGES + 1);

    logic [REG_ADDR_W-1:0]                 rs1D_i;
    logic [REG_ADDR_W-1:0]                 rs2D_i;
    logic                                  rs1_used_i;
    logic                                  rs2_used_i;
    logic [REG_ADDR_W-1:0]                 rdD_i;
    logic                                  rdD_wr_ena_i;
    logic                                  issue_i;
    logic                                  issue_long_i;
    logic [CNT_W-1:0]                      issue_lat_i;
    logic                                  long_done_i;
    logic [REG_ADDR_W-1:0]                 long_done_rd_i;
    logic [FWD_STAGES-1:0][REG_ADDR_W-1:0] fwd_rd_i;
    logic [FWD_STAGES-1:0]                 fwd_wr_ena_i;
    logic [FWD_STAGES-1:0]                 fwd_valid_i;
    logic                                  branch_tkn_i;
    logic                                  pc_en_o;
    logic                                  stallD_o;
    logic                                  bubbleE_o;
    logic                                  flush_o;
    logic [FSEL_W-1:0]                     forwardA_o;
    logic [FSEL_W-1:0]                     forwardB_o;

    modport master (
        output rs1D_i, rs2D_i, rs1_used_i, rs2_used_i, rdD_i, rdD_wr_ena_i,
        output issue_i, issue_long_i, issue_lat_i, long_done_i, long_done_rd_i,
        output fwd_rd_i, fwd_wr_ena_i, fwd_valid_i, branch_tkn_i,
        input  pc_en_o, stallD_o, bubbleE_o, flush_o, forwardA_o, forwardB_o
    );

    modport slave (
        input  rs1D_i, rs2D_i, rs1_used_i, rs2_used_i, rdD_i, rdD_wr_ena_i,
        input  issue_i, issue_long_i, issue_lat_i, long_done_i, long_done_rd_i,
        input  fwd_rd_i, fwd_wr_ena_i, fwd_valid_i, branch_tkn_i,
        output pc_en_o, stallD_o, bubbleE_o, flush_o, forwardA_o, forwardB_o
    );

endinterface

// File: rtl/hazard_sb_unit_scoreboard.sv
// Per-register scoreboard: fixed-latency countdown plus an unknown-latency wait bit.
// Latency: pending reflects a set from the next cycle; backpressure: none, always accepts.
// Reset: synchronous active-high.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 6,
    localparam int NREGS     = 2 ** REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_vld_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic [CNT_W-1:0]      set_lat_i,
    input  logic                  clr_vld_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    output logic [NREGS-1:0]      pending_o,
    output logic                  any_wait_o
);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [NREGS-1:0] wait_q;
    logic [NREGS-1:0] wait_d;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
        end
        wait_d = wait_q;
        if (clr_vld_i) begin
            wait_d[clr_rd_i] = 1'b0;
        end
        // Load L-1: the producer's own issue cycle already counts as one of
        // its L cycles, so a consumer may issue exactly L cycles later.
        if (set_vld_i) begin
            if (set_lat_i == '0) begin
                wait_d[set_rd_i] = 1'b1;
            end else begin
                cnt_d[set_rd_i] = set_lat_i - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            wait_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            wait_q <= wait_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pending_o[r] = (cnt_q[r] != '0) || wait_q[r];
        end
        any_wait_o = |wait_q;
    end

endmodule

// File: rtl/hazard_sb_unit.sv
// Decode-side hazard controller: N-stage forwarding, load-use/RAW/WAW/structural stalls, flush window.
// Latency: all outputs combinational from decode inputs; scoreboard updates at the clock edge.
// Backpressure: stallD_o/bubbleE_o hold decode; flush overrides stall. HAZARD_PERF_EN adds perf counters.
module hazard_sb_unit
    import hazard_sb_unit_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FWD_STAGES   = 3,
    parameter int MAX_LAT      = 34,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_sb_unit_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int NREGS  = 2 ** REG_ADDR_W;
    localparam int CNT_W  = $clog2(MAX_LAT + 1);
    localparam int FSEL_W = $clog2(FWD_STAGES + 1);
    localparam int FW_W   = $clog2(FLUSH_CYCLES + 1);

    logic [NREGS-1:0]  pending;
    logic              any_wait;
    logic [FSEL_W-1:0] sel_a;
    logic [FSEL_W-1:0] sel_b;
    logic              hit_a;
    logic              hit_b;
    logic              hit_a_vld;
    logic              hit_b_vld;
    logic              load_use;
    logic              raw_haz;
    logic              waw_haz;
    logic              struct_haz;
    logic              hazard;
    logic              flush;
    logic              stall;
    logic              sb_set;
    logic [FW_W-1:0]   flush_win_q;
    logic [FW_W-1:0]   flush_win_d;

    // Walk oldest to youngest so the youngest matching stage wins.
    always_comb begin
        sel_a     = FSEL_W'(FWD_RF);
        sel_b     = FSEL_W'(FWD_RF);
        hit_a     = 1'b0;
        hit_b     = 1'b0;
        hit_a_vld = 1'b0;
        hit_b_vld = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hz.fwd_wr_ena_i[k] && (hz.fwd_rd_i[k] == hz.rs1D_i) && (hz.rs1D_i != '0)) begin
                sel_a     = FSEL_W'(fwd_sel_of(k));
                hit_a     = 1'b1;
                hit_a_vld = hz.fwd_valid_i[k];
            end
            if (hz.fwd_wr_ena_i[k] && (hz.fwd_rd_i[k] == hz.rs2D_i) && (hz.rs2D_i != '0)) begin
                sel_b     = FSEL_W'(fwd_sel_of(k));
                hit_b     = 1'b1;
                hit_b_vld = hz.fwd_valid_i[k];
            end
        end
    end

    always_comb begin
        load_use   = (hz.rs1_used_i && hit_a && !hit_a_vld)
                   || (hz.rs2_used_i && hit_b && !hit_b_vld);
        raw_haz    = (hz.rs1_used_i && (hz.rs1D_i != '0) && pending[hz.rs1D_i] && !(hit_a && hit_a_vld))
                   || (hz.rs2_used_i && (hz.rs2D_i != '0) && pending[hz.rs2D_i] && !(hit_b && hit_b_vld));
        waw_haz    = hz.rdD_wr_ena_i && (hz.rdD_i != '0) && pending[hz.rdD_i];
        // Only one unknown-latency unit exists, so a second one must wait.
        struct_haz = hz.issue_long_i && (hz.issue_lat_i == '0) && any_wait;
        hazard     = load_use || raw_haz || waw_haz || struct_haz;
        flush      = !rst_i && (hz.branch_tkn_i || (flush_win_q != '0));
        stall      = !rst_i && hazard && !flush;
        sb_set     = hz.issue_i && !hazard && !flush && hz.issue_long_i
                   && hz.rdD_wr_ena_i && (hz.rdD_i != '0);
    end

    always_comb begin
        hz.stallD_o   = stall;
        hz.bubbleE_o  = stall;
        hz.pc_en_o    = !stall;
        hz.flush_o    = flush;
        hz.forwardA_o = rst_i ? FSEL_W'(FWD_RF) : sel_a;
        hz.forwardB_o = rst_i ? FSEL_W'(FWD_RF) : sel_b;
    end

    always_comb begin
        flush_win_d = flush_win_q;
        if (hz.branch_tkn_i) begin
            flush_win_d = FW_W'(FLUSH_CYCLES - 1);
        end else if (flush_win_q != '0) begin
            flush_win_d = flush_win_q - FW_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_win_q <= '0;
        end else begin
            flush_win_q <= flush_win_d;
        end
    end

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_vld_i  (sb_set),
        .set_rd_i   (hz.rdD_i),
        .set_lat_i  (hz.issue_lat_i),
        .clr_vld_i  (hz.long_done_i),
        .clr_rd_i   (hz.long_done_rd_i),
        .pending_o  (pending),
        .any_wait_o (any_wait)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sb_unit.sv
// Bench for hazard_sb_unit: forwarding vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-number reference model.
module tb_hazard_sb_unit;

    localparam int RAW_ = 5;
    localparam int NREG = 32;
    localparam int FC   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_sb_unit_if #(.REG_ADDR_W(5), .FWD_STAGES(3), .MAX_LAT(34)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    hazard_sb_unit #(
        .REG_ADDR_W   (5),
        .FWD_STAGES   (3),
        .MAX_LAT      (34),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (bus)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a register is busy until an absolute cycle number,
    // or until its unknown-latency completion arrives.
    int cyc = 0;
    int ready_at [NREG];
    bit waiting  [NREG];
    int flush_until = 0;
    int m_fa, m_fb;
    bit m_haz, m_flush, m_stall;

    typedef struct {
        bit [4:0] rs1, rs2;
        bit       u1, u2;
        bit [4:0] fr0, fr1, fr2;
        bit [2:0] we, vld;
        int       efa, efb;
        int       est;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit busy(input int r);
        return (r != 0) && ((cyc < ready_at[r]) || waiting[r]);
    endfunction

    function automatic bit any_waiting();
        for (int r = 0; r < NREG; r++) if (waiting[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic fsel(input bit [4:0] rs, output int sel, output bit vld);
        sel = 0;
        vld = 1'b0;
        if (rs != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (bus.fwd_wr_ena_i[k] && bus.fwd_rd_i[k] == rs) begin
                    sel = k + 1;
                    vld = bus.fwd_valid_i[k];
                    break;
                end
            end
        end
    endtask

    task automatic model_eval();
        int sa, sb;
        bit va, vb, lu, raw, waw, st;
        fsel(bus.rs1D_i, sa, va);
        fsel(bus.rs2D_i, sb, vb);
        lu  = (bus.rs1_used_i && sa != 0 && !va) || (bus.rs2_used_i && sb != 0 && !vb);
        raw = (bus.rs1_used_i && busy(int'(bus.rs1D_i)) && !(sa != 0 && va))
           || (bus.rs2_used_i && busy(int'(bus.rs2D_i)) && !(sb != 0 && vb));
        waw = bus.rdD_wr_ena_i && busy(int'(bus.rdD_i));
        st  = bus.issue_long_i && bus.issue_lat_i == 0 && any_waiting();
        m_haz   = lu || raw || waw || st;
        m_flush = !rst && (bus.branch_tkn_i || cyc < flush_until);
        m_stall = !rst && m_haz && !m_flush;
        m_fa    = rst ? 0 : sa;
        m_fb    = rst ? 0 : sb;
    endtask

    task automatic model_commit();
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                ready_at[r] = 0;
                waiting[r]  = 1'b0;
            end
            flush_until = 0;
        end else begin
            if (bus.branch_tkn_i) flush_until = cyc + FC;
            if (bus.long_done_i) waiting[bus.long_done_rd_i] = 1'b0;
            if (bus.issue_i && !m_haz && !m_flush && bus.issue_long_i
                && bus.rdD_wr_ena_i && bus.rdD_i != 0) begin
                if (bus.issue_lat_i == 0) waiting[bus.rdD_i] = 1'b1;
                else ready_at[bus.rdD_i] = cyc + int'(bus.issue_lat_i);
            end
        end
        cyc++;
    endtask

    task automatic idle_in();
        bus.rs1D_i = '0; bus.rs2D_i = '0; bus.rs1_used_i = 0; bus.rs2_used_i = 0;
        bus.rdD_i = '0; bus.rdD_wr_ena_i = 0; bus.issue_i = 0; bus.issue_long_i = 0;
        bus.issue_lat_i = '0; bus.long_done_i = 0; bus.long_done_rd_i = '0;
        bus.fwd_rd_i = '0; bus.fwd_wr_ena_i = '0; bus.fwd_valid_i = '0;
        bus.branch_tkn_i = 0;
    endtask

    task automatic issue_long(input bit [4:0] rd, input bit [5:0] lat);
        idle_in();
        bus.issue_i = 1; bus.issue_long_i = 1; bus.issue_lat_i = lat;
        bus.rdD_i = rd; bus.rdD_wr_ena_i = 1;
    endtask

    task automatic read_rs1(input bit [4:0] rs);
        idle_in();
        bus.rs1D_i = rs; bus.rs1_used_i = 1;
    endtask

    // One clock: check outputs mid-cycle against the model (and optional
    // directed constants), then advance the model across the edge.
    task automatic cycle(input int exp_stall = -1, input int exp_flush = -1);
        #4;
        model_eval();
        chk("pc_en",     int'(bus.pc_en_o),    int'(!m_stall));
        chk("stallD",    int'(bus.stallD_o),   int'(m_stall));
        chk("bubbleE",   int'(bus.bubbleE_o),  int'(m_stall));
        chk("flush",     int'(bus.flush_o),    int'(m_flush));
        chk("forwardA",  int'(bus.forwardA_o), m_fa);
        chk("forwardB",  int'(bus.forwardB_o), m_fb);
        if (exp_stall >= 0) chk("dir_stall", int'(bus.stallD_o), exp_stall);
        if (exp_flush >= 0) chk("dir_flush", int'(bus.flush_o), exp_flush);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            ready_at[r] = 0;
            waiting[r]  = 1'b0;
        end
        //            rs1 rs2 u1 u2 fr0 fr1 fr2 we    vld    fa fb st
        vecs[0] = '{5, 0, 1, 0, 5, 5, 0, 3'b011, 3'b011, 1, 0, 0};
        vecs[1] = '{5, 0, 1, 0, 6, 5, 5, 3'b111, 3'b111, 2, 0, 0};
        vecs[2] = '{0, 0, 1, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0};
        vecs[3] = '{0, 7, 0, 1, 7, 0, 0, 3'b001, 3'b000, 0, 1, 1};
        vecs[4] = '{0, 7, 0, 0, 7, 0, 0, 3'b001, 3'b000, 0, 1, 0};
        vecs[5] = '{0, 7, 0, 1, 0, 7, 0, 3'b010, 3'b010, 0, 2, 0};
        vecs[6] = '{4, 4, 1, 1, 0, 0, 4, 3'b100, 3'b100, 3, 3, 0};
        vecs[7] = '{4, 0, 1, 0, 4, 0, 0, 3'b000, 3'b111, 0, 0, 0};
        vecs[8] = '{8, 0, 1, 0, 8, 8, 0, 3'b011, 3'b010, 1, 0, 1};

        idle_in();
        rst = 1;
        @(posedge clk); #1;
        cycle(0, 0);
        rst = 0;

        // Forwarding / load-use vectors with an empty scoreboard.
        foreach (vecs[i]) begin
            idle_in();
            bus.rs1D_i = vecs[i].rs1; bus.rs2D_i = vecs[i].rs2;
            bus.rs1_used_i = vecs[i].u1; bus.rs2_used_i = vecs[i].u2;
            bus.fwd_rd_i[0] = vecs[i].fr0; bus.fwd_rd_i[1] = vecs[i].fr1;
            bus.fwd_rd_i[2] = vecs[i].fr2;
            bus.fwd_wr_ena_i = vecs[i].we; bus.fwd_valid_i = vecs[i].vld;
            #4;
            chk($sformatf("vec%0d_fwdA", i), int'(bus.forwardA_o), vecs[i].efa);
            chk($sformatf("vec%0d_fwdB", i), int'(bus.forwardB_o), vecs[i].efb);
            chk($sformatf("vec%0d_stall", i), int'(bus.stallD_o), vecs[i].est);
            chk($sformatf("vec%0d_pc_en", i), int'(bus.pc_en_o), 1 - vecs[i].est);
            @(posedge clk); model_commit(); #1;
        end

        // Fixed-latency mul x9, L=4: dependents stall t+1..t+3, go at t+4.
        issue_long(9, 6'd4); cycle(0);
        read_rs1(9); cycle(1); cycle(1); cycle(1); cycle(0);
        // L=1 never stalls.
        issue_long(11, 6'd1); cycle(0);
        read_rs1(11); cycle(0);

        // Unknown-latency div x3; WAW and a second div stall until done.
        issue_long(3, 6'd0); cycle(0);
        idle_in(); bus.rdD_i = 3; bus.rdD_wr_ena_i = 1; bus.issue_i = 1;
        cycle(1); cycle(1);
        issue_long(10, 6'd0); cycle(1);
        idle_in(); bus.rdD_i = 3; bus.rdD_wr_ena_i = 1; bus.issue_i = 1;
        bus.long_done_i = 1; bus.long_done_rd_i = 3; cycle(1);
        bus.long_done_i = 0; cycle(0);

        // Flush window of 2 overrides a RAW stall; pending entry survives.
        issue_long(12, 6'd6); cycle(0);
        read_rs1(12); bus.branch_tkn_i = 1; cycle(0, 1);
        bus.branch_tkn_i = 0; cycle(0, 1);
        cycle(1, 0);

        // Reset drops pending state at the edge.
        issue_long(13, 6'd20); cycle(0);
        read_rs1(13); cycle(1);
        rst = 1; bus.branch_tkn_i = 1; cycle(0, 0);
        rst = 0; read_rs1(13); cycle(0, 0);

        // Randomized traffic over a small register window for dense hits.
        for (int n = 0; n < 800; n++) begin
            bus.rs1D_i       = 5'($urandom_range(7));
            bus.rs2D_i       = 5'($urandom_range(7));
            bus.rs1_used_i   = 1'($urandom_range(1));
            bus.rs2_used_i   = 1'($urandom_range(1));
            bus.rdD_i        = 5'($urandom_range(7));
            bus.rdD_wr_ena_i = 1'($urandom_range(1));
            bus.issue_i      = ($urandom_range(3) != 0);
            bus.issue_long_i = ($urandom_range(2) == 0);
            bus.issue_lat_i  = ($urandom_range(15) == 0) ? 6'd34 : 6'($urandom_range(6));
            bus.long_done_i  = ($urandom_range(5) == 0);
            bus.long_done_rd_i = 5'($urandom_range(7));
            for (int k = 0; k < 3; k++) bus.fwd_rd_i[k] = 5'($urandom_range(7));
            bus.fwd_wr_ena_i = 3'($urandom_range(7));
            bus.fwd_valid_i  = 3'($urandom_range(7));
            bus.branch_tkn_i = ($urandom_range(11) == 0);
            rst              = ($urandom_range(99) == 0);
            cycle();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
